// File: rtl/soc_system_pio_cmd_pkg.sv
// soc_system_pio_cmd_pkg: register map, status bit positions and FSM state
// type shared by the command PIO and its timer.
package soc_system_pio_cmd_pkg;

  // Avalon word addresses
  localparam logic [1:0] ADDR_DATA   = 2'd0;
  localparam logic [1:0] ADDR_CTRL   = 2'd1;
  localparam logic [1:0] ADDR_STATUS = 2'd2;
  localparam logic [1:0] ADDR_COUNT  = 2'd3;

  // CONTROL bits
  localparam int CTRL_GO     = 0;
  localparam int CTRL_IRQ_EN = 1;

  // STATUS bits
  localparam int ST_BUSY = 0;
  localparam int ST_OVF  = 1;
  localparam int ST_TMO  = 2;
  localparam int ST_DONE = 3;

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_ISSUE     = 2'd1,
    S_WAIT_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/soc_system_pio_cmd_timer.sv
// soc_system_pio_cmd_timer: loadable down-counter guarding WAIT_DONE.
// load_i presets TIMEOUT_CYCLES-1; each enabled cycle counts down and the
// counter parks at zero. expired_o is high while the count is zero, so the
// TIMEOUT_CYCLES-th enabled cycle after the load sees expired_o=1.
module soc_system_pio_cmd_timer #(
  parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
  input  logic clk,
  input  logic reset,
  input  logic load_i,
  input  logic en_i,
  output logic expired_o
);
  localparam int unsigned TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0] LOAD_VAL = TW'(TIMEOUT_CYCLES - 1);

  logic [TW-1:0] cnt_q, cnt_d;

  // next count: load has priority over counting, saturate at zero
  always_comb begin
    cnt_d = cnt_q;
    if (load_i)
      cnt_d = LOAD_VAL;
    else if (en_i && (cnt_q != '0))
      cnt_d = cnt_q - 1'b1;
  end

  // count register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign expired_o = (cnt_q == '0);

endmodule

// File: rtl/soc_system_pio_cmd.sv
// soc_system_pio_cmd: Avalon-MM command PIO. Software writes a command word,
// pulses GO, and the word is offered to the zoom coprocessor over
// valid/ready; completion, overflow and timeout are tracked for polling.
// Optional feature macro SOC_SYSTEM_PIO_CMD_IRQ_EN adds a completion irq.
module soc_system_pio_cmd
  import soc_system_pio_cmd_pkg::*;
#(
  parameter int DATA_W         = 8,
  parameter int TIMEOUT_CYCLES = 1000000,
  parameter int CNT_W          = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [1:0]        address,
  input  logic              chipselect,
  input  logic              write_n,
  input  logic [31:0]       writedata,
  output logic [31:0]       readdata,
  output logic              cmd_valid,
  input  logic              cmd_ready,
  output logic [DATA_W-1:0] cmd_data,
  input  logic              cmd_done
`ifdef SOC_SYSTEM_PIO_CMD_IRQ_EN
  ,
  output logic              irq
`endif
);

  // bus decode
  logic wr, wr_data, wr_ctrl, wr_status, wr_count, go;
  assign wr        = chipselect & ~write_n;
  assign wr_data   = wr & (address == ADDR_DATA);
  assign wr_ctrl   = wr & (address == ADDR_CTRL);
  assign wr_status = wr & (address == ADDR_STATUS);
  assign wr_count  = wr & (address == ADDR_COUNT);
  assign go        = wr_ctrl & writedata[CTRL_GO];

  logic unused_wdata;
  assign unused_wdata = ^writedata;

  state_e            state_q;
  logic [DATA_W-1:0] data_q, cmd_q;
  logic              cmd_valid_q;
  logic              ovf_q, ovf_d, tmo_q, tmo_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [31:0]       rd_d;
  logic              tmr_expired, accept, done_evt, tmo_evt, busy;

  assign busy     = (state_q != S_IDLE);
  assign accept   = (state_q == S_ISSUE) & cmd_ready;
  assign done_evt = (state_q == S_WAIT_DONE) & cmd_done;
  // completion in the same cycle as expiry counts as a completion
  assign tmo_evt  = (state_q == S_WAIT_DONE) & ~cmd_done & tmr_expired;

  soc_system_pio_cmd_timer #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timer (
    .clk       (clk),
    .reset     (reset),
    .load_i    (accept),
    .en_i      (state_q == S_WAIT_DONE),
    .expired_o (tmr_expired)
  );

  // DATA register
  always_ff @(posedge clk or posedge reset) begin
    if (reset)        data_q <= '0;
    else if (wr_data) data_q <= writedata[DATA_W-1:0];
  end

  // command FSM; cmd_valid/cmd_data are registered and held through ISSUE
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      cmd_valid_q <= 1'b0;
      cmd_q       <= '0;
    end else begin
      case (state_q)
        S_IDLE: if (go) begin
          cmd_q       <= data_q;
          cmd_valid_q <= 1'b1;
          state_q     <= S_ISSUE;
        end
        S_ISSUE: if (cmd_ready) begin
          cmd_valid_q <= 1'b0;
          state_q     <= S_WAIT_DONE;
        end
        S_WAIT_DONE: if (cmd_done || tmr_expired) state_q <= S_IDLE;
        default: begin
          cmd_valid_q <= 1'b0;
          state_q     <= S_IDLE;
        end
      endcase
    end
  end

  assign cmd_valid = cmd_valid_q;
  assign cmd_data  = cmd_q;

  // sticky status and counter next-state: set beats W1C, clear beats increment
  always_comb begin
    ovf_d = (go & busy) | (ovf_q & ~(wr_status & writedata[ST_OVF]));
    tmo_d = tmo_evt     | (tmo_q & ~(wr_status & writedata[ST_TMO]));
    cnt_d = cnt_q;
    if (wr_count)      cnt_d = '0;
    else if (done_evt) cnt_d = cnt_q + 1'b1;
  end

  // status and counter registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ovf_q <= 1'b0;
      tmo_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      ovf_q <= ovf_d;
      tmo_q <= tmo_d;
      cnt_q <= cnt_d;
    end
  end

`ifdef SOC_SYSTEM_PIO_CMD_IRQ_EN
  logic irq_en_q, pend_q, pend_d, irq_q;

  always_comb pend_d = done_evt | (pend_q & ~(wr_status & writedata[ST_DONE]));

  // irq enable, completion-pending flag and registered irq
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      irq_en_q <= 1'b0;
      pend_q   <= 1'b0;
      irq_q    <= 1'b0;
    end else begin
      if (wr_ctrl) irq_en_q <= writedata[CTRL_IRQ_EN];
      pend_q <= pend_d;
      irq_q  <= irq_en_q & pend_q;
    end
  end

  assign irq = irq_q;
`endif

  // read mux; unused bits stay zero
  always_comb begin
    rd_d = '0;
    case (address)
      ADDR_DATA: rd_d[DATA_W-1:0] = data_q;
      ADDR_CTRL: begin
`ifdef SOC_SYSTEM_PIO_CMD_IRQ_EN
        rd_d[CTRL_IRQ_EN] = irq_en_q;
`endif
      end
      ADDR_STATUS: begin
        rd_d[ST_BUSY] = busy;
        rd_d[ST_OVF]  = ovf_q;
        rd_d[ST_TMO]  = tmo_q;
`ifdef SOC_SYSTEM_PIO_CMD_IRQ_EN
        rd_d[ST_DONE] = pend_q;
`endif
      end
      default: rd_d[CNT_W-1:0] = cnt_q;
    endcase
  end

  // one-cycle read latency
  always_ff @(posedge clk or posedge reset) begin
    if (reset) readdata <= '0;
    else       readdata <= rd_d;
  end

endmodule

// File: doc/soc_system_pio_cmd.md
Name: soc_system_pio_cmd

Overview:
- Avalon-MM slave that lets the HPS write a command word and launch it into the zoom coprocessor over a valid/ready handshake.
- Tracks busy, completion, overflow and timeout for software polling.
- Write-direction counterpart of the status input PIO. Sits on the lightweight HPS-to-FPGA bridge next to the status PIO.

Parameters:
- DATA_W, 8, command word width (1..32).
- TIMEOUT_CYCLES, 1000000, clk cycles allowed in WAIT_DONE before abort (>=2).
- CNT_W, 8, width of the completed-command counter.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- address  in  2  Avalon word address.
- chipselect  in  1  slave select.
- write_n  in  1  active-low write strobe.
- writedata  in  32  write data.
- readdata  out  32  registered read data.
- cmd_valid  out  1  command offered to coprocessor.
- cmd_ready  in  1  coprocessor accepts command.
- cmd_data  out  DATA_W  command word.
- cmd_done  in  1  single-cycle completion pulse from coprocessor.

Behaviour:
- Write strobe = chipselect & ~write_n.
- readdata: updated every clk from the address mux (1-cycle read latency). Unused bits are 0. Reset value 0.
- Register map:
  - 0 DATA: writedata[DATA_W-1:0] loads data_reg. Readback = data_reg. Reset 0.
  - 1 CONTROL: writing bit0=1 is a GO request. Readback = 0.
  - 2 STATUS: bit0 busy (state != IDLE), bit1 overflow (sticky), bit2 timeout (sticky). Writing 1 to bit1 or bit2 clears that bit (write-1-to-clear).
  - 3 DONE_COUNT: CNT_W-bit count of completed commands, wraps from 2^CNT_W-1 to 0. Any write clears it to 0.
- FSM states: IDLE, ISSUE, WAIT_DONE. Reset state is IDLE.
  - IDLE: a GO loads cmd_reg <= data_reg and moves to ISSUE next cycle. A DATA write in the same cycle as GO is not seen; the old data_reg is latched.
  - ISSUE: cmd_valid=1 and cmd_data=cmd_reg, both held stable until cmd_ready. On cmd_valid&cmd_ready, go to WAIT_DONE and load the timer. ISSUE has no timeout.
  - WAIT_DONE: on cmd_done, go to IDLE and increment DONE_COUNT. If the timer expires (TIMEOUT_CYCLES cycles since entry without cmd_done), set timeout and go to IDLE without incrementing.
  - If cmd_done and timer expiry occur in the same cycle, done wins: count increments, timeout is not set.
- cmd_done in IDLE or ISSUE is ignored.
- GO while state != IDLE: set overflow; command dropped; FSM unaffected. This includes the cycle in which the FSM is returning to IDLE, because the state is evaluated on the registered current state.
- A DONE_COUNT clear write in the same cycle as an increment: the clear wins.
- A W1C write in the same cycle as the set event for the same bit: the set wins.
- Reset mid-operation: state returns to IDLE, cmd_valid=0, cmd_data=0, all registers and the counter are 0. In-flight commands are abandoned.
- Outputs at reset: readdata=0, cmd_valid=0, cmd_data=0.

Optional Feature:
- Macro: SOC_SYSTEM_PIO_CMD_IRQ_EN.
- With the macro:
  - Adds output port irq (1 bit).
  - CONTROL bit1 is a sticky irq_enable, read back on CONTROL bit1.
  - STATUS bit3 is done_pending: set on each completion, cleared by writing 1 to it.
  - irq = irq_enable & done_pending, registered; reset 0.
- Without the macro: no irq port, CONTROL bit1 is ignored and reads 0, STATUS bit3 reads 0.

Decomposition:
- Package soc_system_pio_cmd_pkg holds:
  - address constants ADDR_DATA/ADDR_CTRL/ADDR_STATUS/ADDR_COUNT;
  - status bit indices;
  - state enum type.
- Sub-module soc_system_pio_cmd_timer: loadable down-counter with load, enable and expired outputs, sized by clog2(TIMEOUT_CYCLES).

Test Plan:
1. Reset, then read all four addresses -> readdata=0 for each; cmd_valid=0.
2. Write DATA=0xA5, GO, cmd_ready held low 5 cycles then high, cmd_done 3 cycles later -> cmd_data=0xA5 stable throughout ISSUE; busy=1 until done; DONE_COUNT=1; STATUS=0 afterwards.
3. GO during WAIT_DONE -> STATUS=0x3 (busy+overflow); write STATUS=0x2 -> overflow cleared; original command still completes normally.
4. TIMEOUT_CYCLES=16, accept the command, never pulse cmd_done -> exactly 16 cycles after acceptance FSM is IDLE, STATUS=0x4, DONE_COUNT unchanged; cmd_done asserted on the expiry cycle instead -> DONE_COUNT+1, timeout=0.
5. Run 256 commands with CNT_W=8 -> DONE_COUNT wraps to 0; a clear write coincident with a completion -> reads 0.
6. With SOC_SYSTEM_PIO_CMD_IRQ_EN: CONTROL=0x2, complete a command -> irq=1 the cycle after done_pending sets; write STATUS=0x8 -> irq=0. Assert reset in ISSUE -> cmd_valid=0 and irq=0 immediately.
